decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 60 ++++++
 rtl/decode_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Decode stage port bundle: fetch offer, EX handoff,
// forwarding selects, writeback port and fetch redirect.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc_plus4;
  logic            if_ready;

  logic            id_valid;
  logic            id_ready;
  logic            stall_req;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc_plus4;
  logic [4:0]      id_rs;
  logic [4:0]      id_rt;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_rd1;
  logic [XLEN-1:0] id_rd2;

  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic [XLEN-1:0] mem_alu_out;

  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output if_valid, if_instr, if_pc_plus4,
    input  if_ready,
    input  id_valid,
    output id_ready, stall_req,
    input  id_instr, id_pc_plus4,
    input  id_rs, id_rt, id_rd, id_imm,
    input  id_rd1, id_rd2,
    output fwd_a_sel, fwd_b_sel, mem_alu_out,
    output wb_we, wb_addr, wb_data,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  if_valid, if_instr, if_pc_plus4,
    output if_ready,
    output id_valid,
    input  id_ready, stall_req,
    output id_instr, id_pc_plus4,
    output id_rs, id_rt, id_rd, id_imm,
    output id_rd1, id_rd2,
    input  fwd_a_sel, fwd_b_sel, mem_alu_out,
    input  wb_we, wb_addr, wb_data,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS-style decode stage: IF/ID register, register file,
// operand forwarding and branch/jump resolution.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DELAY_SLOT = 1
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef logic [XLEN-1:0] word_t;

  logic          valid_q;
  logic [31:0]   instr_q;
  word_t         pc4_q;
  word_t         rf [NREG];

  logic          fire;
  logic          flush;
  logic          taken;
  logic          redir;
  word_t         tgt;
  word_t         imm;
  word_t         br_tgt;
  word_t         j_tgt;
  word_t         rf_a;
  word_t         rf_b;
  word_t         rd1;
  word_t         rd2;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic [4:0]    rt;
  logic          neg;
  logic          zero;

  logic is_jabs;
  logic is_jreg;
  logic is_beq;
  logic is_bne;
  logic is_blez;
  logic is_bgtz;
  logic is_bltz;
  logic is_bgez;

  assign fire  = valid_q & bus.id_ready & ~bus.stall_req;
  assign redir = fire & taken;
  assign flush = (DELAY_SLOT == 0) & redir;

  assign bus.id_valid = valid_q & ~bus.stall_req;
  assign bus.if_ready = ~valid_q | fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else if (bus.if_ready) begin
      valid_q <= bus.if_valid & ~flush;
      instr_q <= bus.if_instr;
      pc4_q   <= bus.if_pc_plus4;
    end
  end

  // Entry 0 is never written, so reset keeps it at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (bus.wb_we && bus.wb_addr != '0) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign ra = instr_q[21 +: AW];
  assign rb = instr_q[16 +: AW];

  // Writeback in the same cycle is visible to the read.
  always_comb begin
    rf_a = rf[ra];
    if (ra == '0) begin
      rf_a = '0;
    end else if (bus.wb_we && bus.wb_addr == ra) begin
      rf_a = bus.wb_data;
    end
  end

  always_comb begin
    rf_b = rf[rb];
    if (rb == '0) begin
      rf_b = '0;
    end else if (bus.wb_we && bus.wb_addr == rb) begin
      rf_b = bus.wb_data;
    end
  end

  always_comb begin
    rd1 = rf_a;
    unique case (bus.fwd_a_sel)
      2'd1:    rd1 = bus.mem_alu_out;
      2'd2:    rd1 = bus.wb_data;
      default: rd1 = rf_a;
    endcase
  end

  always_comb begin
    rd2 = rf_b;
    unique case (bus.fwd_b_sel)
      2'd1:    rd2 = bus.mem_alu_out;
      2'd2:    rd2 = bus.wb_data;
      default: rd2 = rf_b;
    endcase
  end

  assign op    = instr_q[31:26];
  assign rt    = instr_q[20:16];
  assign funct = instr_q[5:0];

  assign is_jabs = (op == 6'h02) | (op == 6'h03);
  assign is_jreg = (op == 6'h00) &
                   ((funct == 6'h08) | (funct == 6'h09));
  assign is_beq  = op == 6'h04;
  assign is_bne  = op == 6'h05;
  assign is_blez = op == 6'h06;
  assign is_bgtz = op == 6'h07;
  assign is_bltz = (op == 6'h01) & (rt == 5'd0);
  assign is_bgez = (op == 6'h01) & (rt == 5'd1);

  assign imm    = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
  assign br_tgt = pc4_q + (imm << 2);
  assign j_tgt  = {pc4_q[XLEN-1:28], instr_q[25:0], 2'b00};

  // Sign bit and zero test give every signed compare against 0.
  assign neg  = rd1[XLEN-1];
  assign zero = rd1 == '0;

  always_comb begin
    taken = 1'b0;
    tgt   = br_tgt;
    unique case (1'b1)
      is_jabs: begin
        taken = 1'b1;
        tgt   = j_tgt;
      end
      is_jreg: begin
        taken = 1'b1;
        tgt   = rd1;
      end
      is_beq:  taken = rd1 == rd2;
      is_bne:  taken = rd1 != rd2;
      is_blez: taken = neg | zero;
      is_bgtz: taken = ~neg & ~zero;
      is_bltz: taken = neg;
      is_bgez: taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

  assign bus.id_instr       = instr_q;
  assign bus.id_pc_plus4    = pc4_q;
  assign bus.id_rs          = instr_q[25:21];
  assign bus.id_rt          = instr_q[20:16];
  assign bus.id_rd          = instr_q[15:11];
  assign bus.id_imm         = imm;
  assign bus.id_rd1         = rd1;
  assign bus.id_rd2         = rd2;
  assign bus.redirect_valid = redir;
  assign bus.redirect_pc    = tgt;
endmodule
